// File: rtl/fp_pkg.sv
// Shared FP datapath definitions: result class encodings, IEEE-754 single field
// positions and the entry format stored by the result collector.
package fp_pkg;

  typedef enum logic [1:0] {
    FP_NORMAL = 2'b00,
    FP_ZERO   = 2'b01,
    FP_INF    = 2'b10,
    FP_NAN    = 2'b11
  } fp_class_e;

  localparam int         EXP_MSB  = 30;
  localparam int         EXP_LSB  = 23;
  localparam int         MAN_W    = 23;
  localparam logic [7:0] EXP_ALL1 = 8'hFF;

  typedef struct packed {
    logic [31:0] c;
    logic        ovf;
    fp_class_e   cls;
  } fp_entry_t;

endpackage

// File: rtl/fp_classify.sv
// Combinational IEEE-754 single classifier: zero (denormals flushed), inf, NaN or normal.
// Zero latency; no handshake.
module fp_classify
  import fp_pkg::*;
(
  input  logic [31:0] i_word,
  output fp_class_e   o_class
);

  logic [EXP_MSB-EXP_LSB:0] w_exp;
  logic [MAN_W-1:0]         w_man;

  assign w_exp = i_word[EXP_MSB:EXP_LSB];
  assign w_man = i_word[MAN_W-1:0];

  always_comb begin
    o_class = FP_NORMAL;
    if (w_exp == '0) begin
      o_class = FP_ZERO;
    end else if (w_exp == EXP_ALL1) begin
      o_class = (w_man == '0) ? FP_INF : FP_NAN;
    end
  end

endmodule

// File: rtl/fp_result_collector.sv
// Classifies multiplier products and buffers them in a first-word fall-through FIFO
// with a saturating overflow counter; one cycle in->out, in_ready = !full (registered).
module fp_result_collector
  import fp_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int OVF_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_c,
  input  logic                     in_overflow,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_c,
  output logic                     out_overflow,
  output logic [1:0]               out_class,
  output logic [$clog2(DEPTH):0]   count,
  output logic [OVF_W-1:0]         ovf_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fp_entry_t          r_mem [DEPTH];
  fp_entry_t          r_head;
  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [CW-1:0]      r_count;
  logic               r_in_rdy;
  logic               r_out_vld;
  logic [OVF_W-1:0]   r_ovf_cnt;

  fp_class_e          w_cls;
  fp_entry_t          w_in_entry;
  fp_entry_t          w_head_nxt;
  logic               w_push;
  logic               w_pop;
  logic [AW-1:0]      w_rd_nxt;
  logic [CW-1:0]      w_count_nxt;

  fp_classify u_classify (
    .i_word  (in_c),
    .o_class (w_cls)
  );

  assign w_in_entry  = '{c: in_c, ovf: in_overflow, cls: w_cls};
  assign w_push      = in_valid & r_in_rdy & ~clear;
  assign w_pop       = r_out_vld & out_ready & ~clear;
  assign w_rd_nxt    = w_pop ? r_rd_ptr + AW'(1) : r_rd_ptr;
  assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
  // The new head is the word being written only when it lands in the head slot.
  assign w_head_nxt  = (w_push && (r_wr_ptr == w_rd_nxt)) ? w_in_entry : r_mem[w_rd_nxt];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_in_entry;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_in_rdy  <= 1'b1;
      r_out_vld <= 1'b0;
      r_head    <= '0;
      r_ovf_cnt <= '0;
    end else if (clear) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_in_rdy  <= 1'b1;
      r_out_vld <= 1'b0;
      r_head    <= '0;
      r_ovf_cnt <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      r_rd_ptr  <= w_rd_nxt;
      r_count   <= w_count_nxt;
      r_in_rdy  <= (w_count_nxt != CW'(DEPTH));
      r_out_vld <= (w_count_nxt != '0);
      // When the FIFO drains, the last popped entry stays on the outputs.
      if (w_count_nxt != '0) begin
        r_head <= w_head_nxt;
      end
      if (w_push && in_overflow && (r_ovf_cnt != '1)) begin
        r_ovf_cnt <= r_ovf_cnt + OVF_W'(1);
      end
    end
  end

  assign in_ready     = r_in_rdy;
  assign out_valid    = r_out_vld;
  assign out_c        = r_head.c;
  assign out_overflow = r_head.ovf;
  assign out_class    = r_head.cls;
  assign count        = r_count;
  assign ovf_count    = r_ovf_cnt;

endmodule
